// File: rtl/pudding_cfg_driver_if.sv
// rtl/pudding_cfg_driver_if.sv - command/response bundle for the PUDDING config driver
interface pudding_cfg_driver_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic [127:0] cmd_data;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         rsp_mismatch;

    modport master (
        output cmd_valid, cmd_write, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_mismatch
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_mismatch
    );
endinterface

// File: rtl/pudding_cfg_driver.sv
// rtl/pudding_cfg_driver.sv - host-side sequencer for the PUDDING 128-bit config pin protocol
module pudding_cfg_driver #(
    parameter int BIT_CYCLES = 4,
    parameter int OBS_SYNC   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    pudding_cfg_driver_if.slave        cmd,
    output logic                       busy,
    output logic                       pud_datum,
    output logic                       pud_shift,
    output logic                       pud_transfer,
    output logic                       pud_dir,
    input  logic [7:0]                 pud_obs
);

    if (BIT_CYCLES < 3 || BIT_CYCLES < OBS_SYNC + 2 || OBS_SYNC < 1) begin : g_bad_params
        $error("pudding_cfg_driver: need BIT_CYCLES >= max(3, OBS_SYNC+2) and OBS_SYNC >= 1");
    end

    localparam int PW = $clog2(BIT_CYCLES);
    localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, W_SHIFT, W_COMMIT, R_COPY, R_SHIFT, RESP} state_t;

    state_t         state;
    logic [PW-1:0]  phase;
    logic [6:0]     bit_cnt;
    logic [127:0]   data_q;
    logic [7:0]     sync_q [OBS_SYNC];
    logic [7:0]     obs_s;
    logic           ready_q;
    logic           rsp_valid_q;
    logic           mismatch_q;
    logic [127:0]   rsp_data_q;
    logic           phase_end;
    logic           bit_end;
    logic [6:0]     next_idx;

    assign obs_s     = sync_q[OBS_SYNC-1];
    assign phase_end = (phase == PH_LAST);
    assign bit_end   = (bit_cnt == 7'd127);
    assign next_idx  = 7'd126 - bit_cnt;

    assign cmd.cmd_ready    = ready_q;
    assign cmd.rsp_valid    = rsp_valid_q;
    assign cmd.rsp_data     = rsp_data_q;
    assign cmd.rsp_mismatch = mismatch_q;
    assign busy             = ~ready_q;

    // data_q holds the write payload, or acts as the capture shift register on reads;
    // either way its top byte is what obs must show at the final check.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase        <= '0;
            bit_cnt      <= '0;
            data_q       <= '0;
            ready_q      <= 1'b1;
            rsp_valid_q  <= 1'b0;
            mismatch_q   <= 1'b0;
            rsp_data_q   <= '0;
            pud_datum    <= 1'b0;
            pud_shift    <= 1'b0;
            pud_transfer <= 1'b0;
            pud_dir      <= 1'b0;
            for (int i = 0; i < OBS_SYNC; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= pud_obs;
            for (int i = 1; i < OBS_SYNC; i++) sync_q[i] <= sync_q[i-1];

            pud_shift    <= 1'b0;
            pud_transfer <= 1'b0;
            pud_dir      <= 1'b0;
            rsp_valid_q  <= 1'b0;

            case (state)
                IDLE: begin
                    pud_datum <= 1'b0;
                    if (cmd.cmd_valid && ready_q) begin
                        ready_q <= 1'b0;
                        phase   <= '0;
                        bit_cnt <= '0;
                        data_q  <= cmd.cmd_data;
                        if (cmd.cmd_write) begin
                            pud_datum <= cmd.cmd_data[127];
                            pud_shift <= 1'b1;
                            state     <= W_SHIFT;
                        end else begin
                            pud_transfer <= 1'b1;
                            state        <= R_COPY;
                        end
                    end
                end
                W_SHIFT: begin
                    if (phase_end) begin
                        phase <= '0;
                        if (bit_end) begin
                            pud_datum    <= 1'b0;
                            pud_transfer <= 1'b1;
                            pud_dir      <= 1'b1;
                            state        <= W_COMMIT;
                        end else begin
                            bit_cnt   <= bit_cnt + 7'd1;
                            pud_datum <= data_q[next_idx];
                            pud_shift <= 1'b1;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                W_COMMIT: begin
                    if (phase_end) begin
                        mismatch_q  <= (obs_s != data_q[127:120]);
                        rsp_data_q  <= '0;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                R_COPY: begin
                    if (phase_end) begin
                        phase     <= '0;
                        data_q    <= {data_q[126:0], obs_s[7]};
                        pud_datum <= obs_s[7];
                        pud_shift <= 1'b1;
                        state     <= R_SHIFT;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                R_SHIFT: begin
                    if (phase_end) begin
                        phase <= '0;
                        if (bit_end) begin
                            mismatch_q  <= (obs_s != data_q[127:120]);
                            rsp_data_q  <= data_q;
                            rsp_valid_q <= 1'b1;
                            pud_datum   <= 1'b0;
                            state       <= RESP;
                        end else begin
                            // recirculate the captured bit so the chain ends up restored
                            bit_cnt   <= bit_cnt + 7'd1;
                            data_q    <= {data_q[126:0], obs_s[7]};
                            pud_datum <= obs_s[7];
                            pud_shift <= 1'b1;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                RESP: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pudding_cfg_driver.sv
// tb/tb_pudding_cfg_driver.sv - directed bench for pudding_cfg_driver with a daisychain/state target model
module tb_pudding_cfg_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    pudding_cfg_driver_if ifa ();
    pudding_cfg_driver_if ifb ();

    logic busy_a, datum_a, shift_a, trans_a, dir_a;
    logic busy_b, datum_b, shift_b, trans_b, dir_b;
    logic [7:0]   obs_a, obs_b;
    logic [127:0] dc_a = '0, st_a = '0, dc_b = '0, st_b = '0;
    logic         obs_zero = 1'b0;

    logic         sel = 1'b0;
    logic         drv_valid = 1'b0, drv_write = 1'b0;
    logic [127:0] drv_data = '0;

    assign ifa.cmd_valid = drv_valid & ~sel;
    assign ifa.cmd_write = drv_write;
    assign ifa.cmd_data  = drv_data;
    assign ifb.cmd_valid = drv_valid & sel;
    assign ifb.cmd_write = drv_write;
    assign ifb.cmd_data  = drv_data;

    assign obs_a = obs_zero ? 8'h00 : dc_a[127:120];
    assign obs_b = dc_b[127:120];

    pudding_cfg_driver #(.BIT_CYCLES(4), .OBS_SYNC(2)) dut_a (
        .clk(clk), .rst(rst), .cmd(ifa), .busy(busy_a),
        .pud_datum(datum_a), .pud_shift(shift_a), .pud_transfer(trans_a),
        .pud_dir(dir_a), .pud_obs(obs_a)
    );

    pudding_cfg_driver #(.BIT_CYCLES(3), .OBS_SYNC(1)) dut_b (
        .clk(clk), .rst(rst), .cmd(ifb), .busy(busy_b),
        .pud_datum(datum_b), .pud_shift(shift_b), .pud_transfer(trans_b),
        .pud_dir(dir_b), .pud_obs(obs_b)
    );

    // target: shift pushes datum into the chain LSB, transfer copies chain<->state
    always @(posedge clk) begin
        if (shift_a) dc_a <= {dc_a[126:0], datum_a};
        if (trans_a) begin
            if (dir_a) st_a <= dc_a; else dc_a <= st_a;
        end
        if (shift_b) dc_b <= {dc_b[126:0], datum_b};
        if (trans_b) begin
            if (dir_b) st_b <= dc_b; else dc_b <= st_b;
        end
    end

    logic         v_ready, v_busy, v_rsp_valid, v_mism, v_datum, v_shift, v_trans, v_dir;
    logic [127:0] v_rsp_data, v_st, v_dc;
    assign v_ready     = sel ? ifb.cmd_ready    : ifa.cmd_ready;
    assign v_busy      = sel ? busy_b           : busy_a;
    assign v_rsp_valid = sel ? ifb.rsp_valid    : ifa.rsp_valid;
    assign v_rsp_data  = sel ? ifb.rsp_data     : ifa.rsp_data;
    assign v_mism      = sel ? ifb.rsp_mismatch : ifa.rsp_mismatch;
    assign v_datum     = sel ? datum_b : datum_a;
    assign v_shift     = sel ? shift_b : shift_a;
    assign v_trans     = sel ? trans_b : trans_a;
    assign v_dir       = sel ? dir_b   : dir_a;
    assign v_st        = sel ? st_b    : st_a;
    assign v_dc        = sel ? dc_b    : dc_a;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    localparam logic [127:0] PAY  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] AAAA = {8{16'hAAAA}};
    localparam logic [127:0] EDGE = {1'b1, 126'd0, 1'b1};

    // Issues one command and checks latency, per-cycle pin sequence, handshake and response.
    task automatic run_cmd(input logic wr, input logic [127:0] d, input logic [127:0] exp_rsp,
                           input logic exp_mism, input string tag);
        int b, c, j, ph, lat, pin_err, rdy_err;
        logic e_shift, e_trans, e_dir;
        logic [127:0] rd;
        logic mm, got;
        b = sel ? 3 : 4;
        @(negedge clk);
        drv_valid = 1'b1; drv_write = wr; drv_data = d;
        c = 0;
        while (!v_ready && c < 10) begin @(negedge clk); c++; end
        check({tag, "_ready_before"}, v_ready, 1'b1);
        @(posedge clk); #1;
        drv_valid = 1'b0; drv_data = ~d;
        c = 1; lat = 0; pin_err = 0; rdy_err = 0; got = 1'b0; rd = '0; mm = 1'b0;
        while (!got && c <= 700) begin
            j = (c - 1) / b; ph = (c - 1) % b;
            if (wr) begin
                e_shift = (ph == 0) && (j < 128);
                e_trans = (c == 1 + 128 * b);
                e_dir   = e_trans;
                if (j < 128 && v_datum !== d[127-j]) pin_err++;
            end else begin
                e_shift = (ph == 0) && (j >= 1) && (j <= 128);
                e_trans = (c == 1);
                e_dir   = 1'b0;
                if (j >= 1 && j <= 128 && v_datum !== exp_rsp[128-j]) pin_err++;
            end
            if (v_shift !== e_shift || v_trans !== e_trans || v_dir !== e_dir) pin_err++;
            if (v_ready || !v_busy) rdy_err++;
            if (v_rsp_valid) begin
                got = 1'b1; lat = c; rd = v_rsp_data; mm = v_mism;
            end else begin
                @(posedge clk); #1; c++;
            end
        end
        check({tag, "_latency"}, lat, 129 * b + 1);
        check({tag, "_rsp_data"}, rd, exp_rsp);
        check({tag, "_mismatch"}, mm, exp_mism);
        check({tag, "_pin_errors"}, pin_err, 0);
        check({tag, "_busy_errors"}, rdy_err, 0);
        @(posedge clk); #1;
        check({tag, "_ready_after"}, {v_ready, v_rsp_valid}, 2'b10);
        check({tag, "_rsp_held"}, v_rsp_data, exp_rsp);
        if (wr) check({tag, "_model_state"}, v_st, d);
        else    check({tag, "_chain_restored"}, v_dc, v_st);
    endtask

    typedef struct {
        logic         sel;
        logic         wr;
        logic [127:0] data;
        logic [127:0] exp_rsp;
        logic         exp_mism;
        logic         obs_zero;
        string        tag;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int c, rv, rdy_err;
        vecs[0] = '{1'b0, 1'b1, PAY,                 128'd0, 1'b0, 1'b0, "wr_pass"};
        vecs[1] = '{1'b0, 1'b0, 128'hDEAD_BEEF,      PAY,    1'b0, 1'b0, "rd_after_wr"};
        vecs[2] = '{1'b0, 1'b1, ONES,                128'd0, 1'b1, 1'b1, "wr_obs_fault"};
        vecs[3] = '{1'b0, 1'b0, 128'd0,              ONES,   1'b0, 1'b0, "rd_ones"};
        vecs[4] = '{1'b1, 1'b0, 128'd5,              128'd0, 1'b0, 1'b0, "b3_rd_zero"};
        vecs[5] = '{1'b1, 1'b1, EDGE,                128'd0, 1'b0, 1'b0, "b3_wr_edge"};
        vecs[6] = '{1'b1, 1'b0, 128'd0,              EDGE,   1'b0, 1'b0, "b3_rd_edge"};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pins_a", {datum_a, shift_a, trans_a, dir_a}, 4'b0);
        check("reset_pins_b", {datum_b, shift_b, trans_b, dir_b}, 4'b0);
        check("reset_rsp_a", {ifa.rsp_valid, ifa.rsp_mismatch, ifa.rsp_data}, 130'd0);
        check("reset_rsp_b", {ifb.rsp_valid, ifb.rsp_mismatch, ifb.rsp_data}, 130'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", {ifa.cmd_ready, busy_a, ifb.cmd_ready, busy_b}, 4'b1010);

        for (int i = 0; i < 7; i++) begin
            sel = vecs[i].sel;
            obs_zero = vecs[i].obs_zero;
            run_cmd(vecs[i].wr, vecs[i].data, vecs[i].exp_rsp, vecs[i].exp_mism, vecs[i].tag);
            obs_zero = 1'b0;
        end

        // back-to-back: valid held high, write then read of the same pattern
        sel = 1'b0;
        @(negedge clk);
        drv_valid = 1'b1; drv_write = 1'b1; drv_data = AAAA;
        @(posedge clk); #1;
        drv_write = 1'b0;
        c = 1; rdy_err = 0;
        while (!v_rsp_valid && c < 700) begin
            if (v_ready) rdy_err++;
            @(posedge clk); #1; c++;
        end
        check("b2b_first_latency", c, 517);
        check("b2b_first_rsp", {v_mism, v_rsp_data}, 129'd0);
        check("b2b_first_ready_low", {v_ready, rdy_err[0 +: 8]}, 9'd0);
        @(posedge clk); #1;
        check("b2b_idle_gap_ready", v_ready, 1'b1);
        @(posedge clk); #1;
        check("b2b_second_accept", {v_ready, v_trans, v_dir}, 3'b010);
        drv_valid = 1'b0;
        check("b2b_state_written", st_a, AAAA);
        c = 1; rdy_err = 0;
        while (!v_rsp_valid && c < 700) begin
            if (v_ready) rdy_err++;
            @(posedge clk); #1; c++;
        end
        check("b2b_second_latency", c, 517);
        check("b2b_second_rsp", {v_mism, v_rsp_data}, {1'b0, AAAA});
        check("b2b_second_ready_low", rdy_err, 0);

        // reset in the middle of a write, at bit 60
        repeat (2) @(posedge clk);
        @(negedge clk);
        drv_valid = 1'b1; drv_write = 1'b1; drv_data = PAY;
        @(posedge clk); #1;
        drv_valid = 1'b0;
        c = 1;
        while (c < 241) begin @(posedge clk); #1; c++; end
        check("abort_at_bit60_shift", {v_shift, v_datum}, {1'b1, PAY[67]});
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_pins_zero", {datum_a, shift_a, trans_a, dir_a, ifa.rsp_valid}, 5'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", {ifa.cmd_ready, busy_a}, 2'b10);
        rv = 0;
        repeat (600) begin
            if (ifa.rsp_valid || shift_a || trans_a) rv++;
            @(posedge clk); #1;
        end
        check("abort_no_rsp", rv, 0);
        run_cmd(1'b1, ONES, 128'd0, 1'b0, "wr_after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
